mult_div: RTL and testbench

- Multi-cycle integer multiply/divide unit that owns the HI/LO register pair.
- Sits in the execute stage, downstream of the immediate sign/zero extender and the register file.
- Operand B is either a register value or the 32-bit extended immediate; the mux outside this block selects it.
- Control FSM pulses Inicio, waits for Pronto, then reads Hi/Lo (MFHI/MFLO) or writes them (MTHI/MTLO).

---
 rtl/mult_div_pkg.sv | 21 ++
 rtl/mult_div_passo.sv | 48 ++++
 rtl/mult_div.sv | 151 +++++++++++++++
 tb/tb_mult_div.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared definitions for the multiply/divide unit: default operand width,
// control FSM state encoding and operation select encoding.
// Imported by mult_div and mult_div_passo.
package mult_div_pkg;

  // Default operand / Hi / Lo width and number of iterations per operation.
  localparam int LARGURA_PADRAO = 32;

  // Control FSM states.
  typedef enum logic [1:0] {
    OCIOSO = 2'd0,  // idle, accepts Inicio and MTHI/MTLO writes
    CALC   = 2'd1,  // one shift-add / shift-subtract iteration per cycle
    AJUSTE = 2'd2,  // sign correction and Hi/Lo write-back
    FIM    = 2'd3   // one-cycle completion (Pronto)
  } estado_t;

  // Operation select encoding (Op input).
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/mult_div_passo.sv
// Single combinational iteration of the multi-cycle multiply/divide datapath.
// Ports: op_i selects multiply/divide, acc_i is the 2W accumulator,
//        oper_i is the multiplicand magnitude or divisor magnitude, acc_o next accumulator.
module mult_div_passo
  import mult_div_pkg::*;
#(
  parameter int W = LARGURA_PADRAO
) (
  input  logic             op_i,
  input  logic [2*W-1:0]   acc_i,
  input  logic [W-1:0]     oper_i,
  output logic [2*W-1:0]   acc_o
);

  // Multiply: accumulator is {partial product, remaining multiplier bits}.
  // The W+1 bit sum keeps the carry, which becomes the new top bit after the shift.
  logic [W:0] soma;

  // Divide: accumulator is {partial remainder, remaining dividend / quotient bits}.
  // The shifted partial remainder needs W+1 bits before the trial subtract.
  logic [W:0]   parcial;
  logic         cabe;
  logic [W-1:0] resto;

  always_comb begin
    soma    = {1'b0, acc_i[2*W-1:W]} + {1'b0, oper_i};
    parcial = acc_i[2*W-1:W-1];
    cabe    = (parcial >= {1'b0, oper_i});
    // When the divisor fits, the true difference is below 2^W, so W bits suffice.
    resto   = parcial[W-1:0] - oper_i;

    acc_o = acc_i;
    if (op_i == OP_MULT) begin
      if (acc_i[0]) begin
        acc_o = {soma, acc_i[W-1:1]};
      end else begin
        acc_o = {1'b0, acc_i[2*W-1:1]};
      end
    end else begin
      if (cabe) begin
        acc_o = {resto, acc_i[W-2:0], 1'b1};
      end else begin
        acc_o = {parcial[W-1:0], acc_i[W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mult_div.sv
// Multi-cycle integer multiply/divide unit owning the Hi/Lo register pair.
// Ports: clock/reset, Inicio/Op/Sinal/A/B start an operation, EscreveHi/EscreveLo load Hi/Lo from A,
//        Hi/Lo results, Ocupado while computing, Pronto one-cycle done pulse, DivZero with Pronto.
module mult_div
  import mult_div_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               Inicio,
  input  logic               Op,
  input  logic               Sinal,
  input  logic [LARGURA-1:0] A,
  input  logic [LARGURA-1:0] B,
  input  logic               EscreveHi,
  input  logic               EscreveLo,
  output logic [LARGURA-1:0] Hi,
  output logic [LARGURA-1:0] Lo,
  output logic               Ocupado,
  output logic               Pronto,
  output logic               DivZero
);

  localparam int CW = $clog2(LARGURA);

  estado_t              estado_q;
  logic [CW-1:0]        cont_q;
  logic                 op_q;
  logic                 neg_res_q;   // product / quotient must be negated
  logic                 neg_rem_q;   // remainder must be negated (dividend was negative)
  logic [LARGURA-1:0]   oper_q;      // multiplicand or divisor magnitude
  logic [2*LARGURA-1:0] acc_q;
  logic [2*LARGURA-1:0] acc_d;
  logic [LARGURA-1:0]   hi_q;
  logic [LARGURA-1:0]   lo_q;
  logic                 ocupado_q;
  logic                 pronto_q;
  logic                 divzero_q;

  // Operand magnitudes; for unsigned operations the negative flags are forced low.
  logic                 a_neg_d;
  logic                 b_neg_d;
  logic [LARGURA-1:0]   a_mag_d;
  logic [LARGURA-1:0]   b_mag_d;

  // Sign-corrected results, consumed in AJUSTE.
  logic [2*LARGURA-1:0] prod_d;
  logic [LARGURA-1:0]   quoc_d;
  logic [LARGURA-1:0]   rest_d;

  always_comb begin
    a_neg_d = Sinal & A[LARGURA-1];
    b_neg_d = Sinal & B[LARGURA-1];
    a_mag_d = a_neg_d ? (~A + 1'b1) : A;
    b_mag_d = b_neg_d ? (~B + 1'b1) : B;

    prod_d  = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    quoc_d  = neg_res_q ? (~acc_q[LARGURA-1:0] + 1'b1) : acc_q[LARGURA-1:0];
    rest_d  = neg_rem_q ? (~acc_q[2*LARGURA-1:LARGURA] + 1'b1) : acc_q[2*LARGURA-1:LARGURA];
  end

  mult_div_passo #(
    .W (LARGURA)
  ) u_passo (
    .op_i   (op_q),
    .acc_i  (acc_q),
    .oper_i (oper_q),
    .acc_o  (acc_d)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= OCIOSO;
      cont_q    <= '0;
      op_q      <= OP_MULT;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      oper_q    <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      pronto_q <= 1'b0;
      case (estado_q)
        OCIOSO: begin
          // MTHI/MTLO; a result written later overrides this.
          if (EscreveHi) hi_q <= A;
          if (EscreveLo) lo_q <= A;
          if (Inicio) begin
            op_q      <= Op;
            neg_res_q <= a_neg_d ^ b_neg_d;
            neg_rem_q <= a_neg_d;
            if (Op == OP_DIV && B == '0) begin
              // No computation; Hi/Lo keep their contents.
              estado_q  <= FIM;
              pronto_q  <= 1'b1;
              divzero_q <= 1'b1;
            end else begin
              estado_q  <= CALC;
              ocupado_q <= 1'b1;
              cont_q    <= CW'(LARGURA - 1);
              if (Op == OP_MULT) begin
                oper_q <= a_mag_d;
                acc_q  <= {{LARGURA{1'b0}}, b_mag_d};
              end else begin
                oper_q <= b_mag_d;
                acc_q  <= {{LARGURA{1'b0}}, a_mag_d};
              end
            end
          end
        end
        CALC: begin
          acc_q  <= acc_d;
          cont_q <= cont_q - 1'b1;
          if (cont_q == '0) estado_q <= AJUSTE;
        end
        AJUSTE: begin
          if (op_q == OP_MULT) begin
            hi_q <= prod_d[2*LARGURA-1:LARGURA];
            lo_q <= prod_d[LARGURA-1:0];
          end else begin
            hi_q <= rest_d;
            lo_q <= quoc_d;
          end
          estado_q  <= FIM;
          ocupado_q <= 1'b0;
          pronto_q  <= 1'b1;
        end
        FIM: begin
          estado_q  <= OCIOSO;
          divzero_q <= 1'b0;
        end
        default: begin
          estado_q  <= OCIOSO;
          ocupado_q <= 1'b0;
        end
      endcase
    end
  end

  assign Hi      = hi_q;
  assign Lo      = lo_q;
  assign Ocupado = ocupado_q;
  assign Pronto  = pronto_q;
  assign DivZero = divzero_q;

endmodule

// File: tb/tb_mult_div.sv
// Self-checking bench for mult_div: directed corner cases plus randomized operations,
// all compared against a plain-arithmetic reference model of Hi/Lo.
module tb_mult_div;

  logic        clock = 1'b0;
  logic        reset;
  logic        Inicio;
  logic        Op;
  logic        Sinal;
  logic [31:0] A;
  logic [31:0] B;
  logic        EscreveHi;
  logic        EscreveLo;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        Ocupado;
  logic        Pronto;
  logic        DivZero;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference copy of the architectural Hi/Lo.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mult_div #(.LARGURA(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .Inicio    (Inicio),
    .Op        (Op),
    .Sinal     (Sinal),
    .A         (A),
    .B         (B),
    .EscreveHi (EscreveHi),
    .EscreveLo (EscreveLo),
    .Hi        (Hi),
    .Lo        (Lo),
    .Ocupado   (Ocupado),
    .Pronto    (Pronto),
    .DivZero   (DivZero)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: full-width arithmetic, SV division truncates toward zero
  // and % takes the sign of the dividend.
  task automatic model(input logic op, input logic sinal, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint      sp;
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] up;
    dz = 1'b0;
    hi = m_hi;
    lo = m_lo;
    if (op == 1'b0) begin
      if (sinal) begin
        sp = longint'($signed(a)) * longint'($signed(b));
        hi = sp[63:32];
        lo = sp[31:0];
      end else begin
        up = {32'b0, a} * {32'b0, b};
        hi = up[63:32];
        lo = up[31:0];
      end
    end else if (b == 32'b0) begin
      dz = 1'b1;
    end else if (sinal) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      lo = q[31:0];
      hi = r[31:0];
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endtask

  // Watch for any Pronto over n cycles; none is expected.
  task automatic expect_quiet(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (Pronto) seen++;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  // Run one operation. Latency k counts edges after the accepting edge E0 at which
  // Pronto was raised: 33 for a computed result, 0 for divide-by-zero.
  task automatic run_op(input logic op, input logic sinal, input logic [31:0] a, input logic [31:0] b,
                        input bit poke_calc, input bit poke_fim);
    logic [31:0] eh;
    logic [31:0] el;
    logic        edz;
    int          k;
    model(op, sinal, a, b, eh, el, edz);
    @(negedge clock);
    Op = op; Sinal = sinal; A = a; B = b; Inicio = 1'b1;
    @(posedge clock);
    @(negedge clock);
    // Scramble operands after acceptance; the result must not depend on them.
    Inicio = 1'b0; A = $urandom; B = $urandom; Op = 1'($urandom); Sinal = 1'($urandom);
    check("busy_after_start", 64'(Ocupado), 64'(!edz));
    k = 0;
    while (!Pronto && k < 60) begin
      @(negedge clock);
      k++;
      Inicio = (poke_calc && k == 10);
    end
    Inicio = 1'b0;
    check("latency", 64'(k), edz ? 64'd0 : 64'd33);
    check("divzero", 64'(DivZero), 64'(edz));
    check("hi", 64'(Hi), 64'(eh));
    check("lo", 64'(Lo), 64'(el));
    check("busy_in_fim", 64'(Ocupado), 64'd0);
    if (poke_fim) Inicio = 1'b1;
    @(negedge clock);
    Inicio = 1'b0;
    check("pronto_one_cycle", 64'(Pronto), 64'd0);
    check("divzero_cleared", 64'(DivZero), 64'd0);
    check("idle_after", 64'(Ocupado), 64'd0);
    m_hi = eh;
    m_lo = el;
    if (poke_calc || poke_fim) expect_quiet("ignored_inicio", 40);
  endtask

  task automatic write_hilo(input logic wh, input logic wl, input logic [31:0] a);
    @(negedge clock);
    EscreveHi = wh; EscreveLo = wl; A = a;
    @(posedge clock);
    @(negedge clock);
    EscreveHi = 1'b0; EscreveLo = 1'b0;
    if (wh) m_hi = a;
    if (wl) m_lo = a;
    check("mt_hi", 64'(Hi), 64'(m_hi));
    check("mt_lo", 64'(Lo), 64'(m_lo));
  endtask

  logic [31:0] corners [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0007};

  initial begin
    reset = 1'b1; Inicio = 1'b0; Op = 1'b0; Sinal = 1'b0; A = '0; B = '0;
    EscreveHi = 1'b0; EscreveLo = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_hi", 64'(Hi), 64'd0);
    check("rst_lo", 64'(Lo), 64'd0);
    check("rst_busy", 64'(Ocupado), 64'd0);
    check("rst_pronto", 64'(Pronto), 64'd0);
    check("rst_divzero", 64'(DivZero), 64'd0);
    reset = 1'b0;

    // Directed cases.
    run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("umul_hi_const", 64'(Hi), 64'hFFFF_FFFE);
    check("umul_lo_const", 64'(Lo), 64'h0000_0001);
    run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0, 1'b0);  // B from extended imm 0x0007
    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
    check("sdiv_lo_const", 64'(Lo), 64'hFFFF_FFFD);
    check("sdiv_hi_const", 64'(Hi), 64'hFFFF_FFFF);
    run_op(1'b1, 1'b0, 32'd100, 32'd7, 1'b0, 1'b0);
    write_hilo(1'b1, 1'b0, 32'h1234);
    write_hilo(1'b0, 1'b1, 32'h5678);
    run_op(1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 1'b1);
    check("dz_hi_kept", 64'(Hi), 64'h1234);
    check("dz_lo_kept", 64'(Lo), 64'h5678);
    write_hilo(1'b1, 1'b1, 32'hA5A5_5A5A);
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check("ovf_lo_const", 64'(Lo), 64'h8000_0000);
    check("ovf_hi_const", 64'(Hi), 64'h0);

    // Reset at E10 of a multiply.
    @(negedge clock);
    Op = 1'b0; Sinal = 1'b1; A = 32'h1234_5678; B = 32'h9ABC_DEF0; Inicio = 1'b1;
    @(posedge clock);
    @(negedge clock);
    Inicio = 1'b0;
    repeat (9) @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check("abort_hi", 64'(Hi), 64'd0);
    check("abort_lo", 64'(Lo), 64'd0);
    check("abort_busy", 64'(Ocupado), 64'd0);
    check("abort_pronto", 64'(Pronto), 64'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clock);
    reset = 1'b0;
    expect_quiet("no_pronto_after_abort", 40);
    write_hilo(1'b0, 1'b1, 32'hCAFE_BABE);

    // Randomized operations with occasional corner operands and MTHI/MTLO.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 9) == 0) rb = '0;
      if ($urandom_range(0, 7) == 0) write_hilo(1'($urandom), 1'($urandom), $urandom);
      run_op(1'($urandom), 1'($urandom), ra, rb, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
